// File: rtl/norm_32_seq.sv
// Iterative CLZ/CLS normalizer: 16/8/4/2/1 stages, 6 cycles accept-to-result (1 on the zero/all-ones fast path).
// Single operand in flight; result holds until out_ready. Optional `abort` input when NORM_ABORT_EN is defined.
module norm_32_seq #(
  parameter bit FAST_PATH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic        sgn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic [5:0]  cnt,
  output logic        z
`ifdef NORM_ABORT_EN
  ,
  input  logic        abort
`endif
);

  typedef enum logic [2:0] {IDLE, S16, S8, S4, S2, S1, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        z_q, z_d;

  logic [2:0]  lvl;
  logic [5:0]  w;
  logic [4:0]  sh_u, sh_s;
  logic [31:0] top_u, top_s;
  logic        shift_ok;
  logic        abort_i;

`ifdef NORM_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = work_q;
  assign cnt       = cnt_q;
  assign z         = z_q;

  // Stage width w = 2**lvl; test the top w bits (unsigned) or top w+1 bits (signed).
  always_comb begin
    lvl = 3'd0;
    case (state_q)
      S16:     lvl = 3'd4;
      S8:      lvl = 3'd3;
      S4:      lvl = 3'd2;
      S2:      lvl = 3'd1;
      default: lvl = 3'd0;
    endcase
    w        = 6'd1 << lvl;
    sh_u     = 5'(6'd32 - w);
    sh_s     = 5'(6'd31 - w);
    top_u    = work_q >> sh_u;
    top_s    = $unsigned($signed(work_q) >>> sh_s);
    shift_ok = sgn_q ? ((top_s == '0) || (top_s == '1)) : (top_u == '0);
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = a;
          sgn_d   = sgn;
          cnt_d   = 6'd0;
          z_d     = (a == 32'd0);
          state_d = S16;
          if (FAST_PATH) begin
            if (a == 32'd0) begin
              cnt_d   = sgn ? 6'd31 : 6'd32;
              state_d = DONE;
            end else if (sgn && (a == 32'hFFFF_FFFF)) begin
              work_d  = 32'h8000_0000;
              cnt_d   = 6'd31;
              state_d = DONE;
            end
          end
        end
      end
      S16, S8, S4, S2, S1: begin
        if (shift_ok) begin
          work_d = work_q << w;
          cnt_d  = cnt_q | (6'd1 << lvl);
        end
        case (state_q)
          S16:     state_d = S8;
          S8:      state_d = S4;
          S4:      state_d = S2;
          S2:      state_d = S1;
          default: state_d = DONE;
        endcase
        // A zero operand only reaches 31 through the stages; unsigned CLZ of zero is 32.
        if ((state_q == S1) && z_q && !sgn_q) cnt_d = 6'd32;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      work_d  = 32'd0;
      cnt_d   = 6'd0;
      z_d     = 1'b0;
      sgn_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= 32'd0;
      cnt_q   <= 6'd0;
      sgn_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      z_q     <= z_d;
    end
  end

endmodule

// File: tb/tb_norm_32_seq.sv
// Bench for norm_32_seq: fast-path and full-stage instances against a leading-bit-count model.
module tb_norm_32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic        sgn = 1'b0;
  logic        abort = 1'b0;

  logic        iv_f = 0, or_f = 0, ir_f, ov_f, z_f;
  logic [31:0] q_f;
  logic [5:0]  c_f;
  logic        iv_n = 0, or_n = 0, ir_n, ov_n, z_n;
  logic [31:0] q_n;
  logic [5:0]  c_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  norm_32_seq #(.FAST_PATH(1'b1)) u_f (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_f), .in_ready(ir_f), .a(a), .sgn(sgn),
    .out_valid(ov_f), .out_ready(or_f), .q(q_f), .cnt(c_f), .z(z_f)
`ifdef NORM_ABORT_EN
    , .abort(abort)
`endif
  );

  norm_32_seq #(.FAST_PATH(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_n), .in_ready(ir_n), .a(a), .sgn(sgn),
    .out_valid(ov_n), .out_ready(or_n), .q(q_n), .cnt(c_n), .z(z_n)
`ifdef NORM_ABORT_EN
    , .abort(abort)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Normalize by counting: leading zeros, or leading copies of the sign bit beyond the first.
  task automatic model_norm(input logic [31:0] av, input logic sv,
                            output logic [31:0] eq, output logic [5:0] ec, output logic ez);
    int n = 0;
    if (!sv) begin
      while (n < 32 && av[31-n] == 1'b0) n++;
    end else begin
      while (n < 31 && av[30-n] == av[31]) n++;
    end
    eq = (n >= 32) ? 32'd0 : (av << n);
    ec = 6'(n);
    ez = (av == 32'd0);
  endtask

  function automatic logic g_ir(input bit np); return np ? ir_n : ir_f; endfunction
  function automatic logic g_ov(input bit np); return np ? ov_n : ov_f; endfunction
  function automatic logic [31:0] g_q(input bit np); return np ? q_n : q_f; endfunction
  function automatic logic [5:0] g_c(input bit np); return np ? c_n : c_f; endfunction
  function automatic logic g_z(input bit np); return np ? z_n : z_f; endfunction

  task automatic set_iv(input bit np, input logic v);
    if (np) iv_n = v; else iv_f = v;
  endtask
  task automatic set_or(input bit np, input logic v);
    if (np) or_n = v; else or_f = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts one operand, checks latency and result, optionally stalls, then completes the handshake.
  task automatic run_op(input bit np, input logic [31:0] av, input logic sv, input int hold);
    logic [31:0] eq, q0;
    logic [5:0]  ec, c0;
    logic        ez;
    int          lat, elat;
    model_norm(av, sv, eq, ec, ez);
    elat = (!np && (av == 32'd0 || (sv && av == 32'hFFFF_FFFF))) ? 1 : 6;
    lat = 0;
    while (!g_ir(np) && lat < 20) begin tick(); lat++; end
    chk("in_ready_before_accept", g_ir(np), 1'b1);
    a = av; sgn = sv; set_iv(np, 1'b1);
    tick();
    set_iv(np, 1'b0);
    a = $urandom; sgn = 1'($urandom);
    lat = 1;
    while (!g_ov(np) && lat < 20) begin tick(); lat++; end
    chk("latency", lat, elat);
    chk("q", g_q(np), eq);
    chk("cnt", g_c(np), ec);
    chk("z", g_z(np), ez);
    chk("in_ready_busy", g_ir(np), 1'b0);
    q0 = g_q(np); c0 = g_c(np);
    repeat (hold) tick();
    if (hold > 0) begin
      chk("hold_valid", g_ov(np), 1'b1);
      chk("hold_q", g_q(np), q0);
      chk("hold_cnt", g_c(np), c0);
      chk("hold_in_ready", g_ir(np), 1'b0);
    end
    set_or(np, 1'b1);
    tick();
    set_or(np, 1'b0);
    chk("valid_drop", g_ov(np), 1'b0);
    chk("in_ready_after", g_ir(np), 1'b1);
  endtask

  initial begin
    logic [31:0] rv;
    bit          rnp, rsv;
    #2;
    chk("rst_in_ready", ir_f, 1'b1);
    chk("rst_valid", ov_f, 1'b0);
    chk("rst_q", q_f, 32'd0);
    chk("rst_cnt", c_n, 6'd0);
    chk("rst_z", z_n, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(0, 32'h0001_0000, 0, 0);
    chk("t1_q_const", q_f, 32'h8000_0000);
    chk("t1_cnt_const", c_f, 6'd15);
    run_op(1, 32'hFFFF_8000, 1, 0);
    chk("t2a_cnt_const", c_n, 6'd16);
    run_op(0, 32'h0000_0001, 1, 0);
    chk("t2b_q_const", q_f, 32'h4000_0000);
    chk("t2b_cnt_const", c_f, 6'd30);
    run_op(0, 32'h0, 0, 0);
    chk("t3_fast_cnt", c_f, 6'd32);
    run_op(1, 32'h0, 0, 0);
    chk("t3_slow_cnt", c_n, 6'd32);
    run_op(1, 32'h0, 1, 0);
    chk("zero_signed_cnt", c_n, 6'd31);
    run_op(0, 32'hFFFF_FFFF, 1, 0);
    run_op(1, 32'hFFFF_FFFF, 1, 0);
    run_op(0, 32'h8000_0000, 0, 0);
    run_op(1, 32'h4000_0000, 1, 0);
    run_op(0, 32'h00F0_0000, 0, 10);
    run_op(0, 32'h0000_0300, 1, 0);

    // Reset while the full-stage instance is in its S4 stage.
    a = 32'h0000_0001; sgn = 1'b0; iv_n = 1'b1;
    tick();
    iv_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", q_n, 32'd0);
    chk("mid_rst_cnt", c_n, 6'd0);
    chk("mid_rst_valid", ov_n, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_in_ready", ir_n, 1'b1);
    run_op(1, 32'h0000_0001, 0, 0);

`ifdef NORM_ABORT_EN
    a = 32'h0000_1234; sgn = 1'b0; iv_f = 1'b1;
    tick();
    iv_f = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_ready", ir_f, 1'b1);
    chk("abort_q", q_f, 32'd0);
    repeat (8) tick();
    chk("abort_no_valid", ov_f, 1'b0);
    a = 32'h0000_00FF; iv_f = 1'b1;
    tick();
    iv_f = 1'b0;
    repeat (5) tick();
    chk("abort_done_valid", ov_f, 1'b1);
    abort = 1'b1; or_f = 1'b1;
    tick();
    abort = 1'b0; or_f = 1'b0;
    chk("abort_done_cnt", c_f, 6'd0);
    chk("abort_done_valid_drop", ov_f, 1'b0);
    run_op(0, 32'h0000_00FF, 0, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      rnp = 1'($urandom);
      rsv = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       rv = $urandom;
        1:       rv = $urandom >> $urandom_range(0, 31);
        2:       rv = ~($urandom >> $urandom_range(0, 31));
        default: begin
          case ($urandom_range(0, 3))
            0:       rv = 32'h0;
            1:       rv = 32'hFFFF_FFFF;
            2:       rv = 32'h1;
            default: rv = 32'h8000_0000;
          endcase
        end
      endcase
      run_op(rnp, rv, rsv, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
